mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum BUSY cycles without mem_ack before abort (range 1..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port if_req  input  1  instruction-fetch request.
REQ-008 SHALL have port if_addr  input  ADDR_W  fetch byte address.
REQ-009 SHALL have port if_rdata  output  DATA_W  fetched word.
REQ-010 SHALL have port if_ack  output  1  fetch completion pulse.
REQ-011 SHALL have port d_req  input  1  data (load/store) request.
REQ-012 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-013 SHALL have port d_addr  input  ADDR_W  data byte address.
REQ-014 SHALL have port d_wdata  input  DATA_W  store data.
REQ-015 SHALL have port d_rdata  output  DATA_W  load data.
REQ-016 SHALL have port d_ack  output  1  data completion pulse.
REQ-017 SHALL have port bus_err  output  1  timeout flag, valid with if_ack/d_ack.
REQ-018 SHALL have port mem_en  output  1  memory access strobe.
REQ-019 SHALL have port mem_we  output  1  memory write enable.
REQ-020 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-021 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-022 SHALL have port mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-023 SHALL have port mem_ack  input  1  memory completion, one cycle.

Function
REQ-024 SHALL share one single-port memory between the fetch and data requesters, one transaction in flight at a time.
REQ-025 SHALL implement FSM states IDLE, BUSY_IF and BUSY_D.
REQ-026 In IDLE, the arbiter SHALL grant a pending request at the clock edge: a single requester is always granted; both pending are resolved per REQ-040/041.
REQ-027 On grant, the arbiter SHALL register address, we and wdata (we=0 for fetch) and enter the matching BUSY state.
REQ-028 In BUSY_*, mem_en SHALL be 1, with mem_we, mem_addr and mem_wdata driven from the latched values and held stable until exit.
REQ-029 On mem_ack in BUSY_*, the arbiter SHALL register mem_rdata into x_rdata, pulse x_ack=1 for exactly the next cycle with bus_err=0, and return to IDLE.
REQ-030 Latency SHALL be: request sampled at edge N, mem_en high from cycle N+1, mem_ack in cycle K (K≥N+1), x_ack in cycle K+1; minimum 2 cycles.
REQ-031 Requesters SHALL hold req, addr, we and wdata stable until x_ack; a req high during its own x_ack cycle SHALL be treated as a new back-to-back request.
REQ-032 The timeout counter SHALL be cleared on entering BUSY_* and incremented each BUSY cycle without mem_ack.
REQ-033 When the timeout count reaches TIMEOUT, the arbiter SHALL drop mem_en, pulse x_ack with bus_err=1 and x_rdata=0, and return to IDLE.
REQ-034 If mem_ack coincides with the timeout cycle, the transaction SHALL complete normally with bus_err=0.
REQ-035 mem_ack in IDLE SHALL be ignored.
REQ-036 if_ack and d_ack SHALL never be high in the same cycle.
REQ-037 x_rdata SHALL hold its value until the next completion on that port; d_rdata SHALL be unchanged after a store.

Reset
REQ-038 Reset assertion SHALL take effect asynchronously, at any time including mid-transaction: state=IDLE; all outputs=0; counter=0; the in-flight transaction is abandoned with no ack.
REQ-039 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-040 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority, with the data port winning when both request.
REQ-041 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, grant the port not granted last; a last_grant register resets to IF so that data wins the first tie.

Verification
REQ-042 Bench SHALL cover: if_req, if_addr=0x10, mem_ack 1 cycle after mem_en, mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_ack next cycle, if_rdata=0x00500093, bus_err=0.
REQ-043 Bench SHALL cover: d_req+d_we, d_addr=0x200, d_wdata=0xDEADBEEF, mem_ack after 3 cycles -> mem_we=1, mem_wdata held 0xDEADBEEF for 3 cycles, single d_ack pulse.
REQ-044 Bench SHALL cover: if_req and d_req held together for 4 transactions -> fixed build grants D,D,D,D while d_req stays high; MEM_ARB_RR_EN build grants D,IF,D,IF.
REQ-045 Bench SHALL cover: d_req load, mem_ack never asserted -> after 16 BUSY cycles, d_ack=1, bus_err=1, d_rdata=0, mem_en=0; mem_ack exactly on cycle 16 -> bus_err=0.
REQ-046 Bench SHALL cover: rst_n pulled low 2 cycles into BUSY_D -> mem_en=0 immediately, no d_ack; after release a new if_req completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data (load/store) port, one transaction in flight at a time.
// A BUSY transaction that sees no mem_ack for TIMEOUT cycles is aborted
// and completed with bus_err=1.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking;
// without it the data port wins every tie.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              bus_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY_IF = 2'd1;
   localparam logic [1:0] BUSY_D  = 2'd2;

   // Last BUSY cycle index before the transaction is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              bus_err_q, bus_err_d;
   logic              pick_d;

`ifdef MEM_ARB_RR_EN
   logic last_d_q, last_d_d;

   // Round-robin: on a tie the port not granted last wins; a lone request always wins.
   always_comb begin
      pick_d   = d_req & (~if_req | ~last_d_q);
      last_d_d = last_d_q;
      if ((state_q == IDLE) && (if_req || d_req)) begin
         last_d_d = pick_d;
      end
   end

   // Remember which port was granted most recently; IF after reset so data wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d_q <= 1'b0;
      end else begin
         last_d_q <= last_d_d;
      end
   end
`else
   // Fixed priority: the data port wins whenever it is requesting.
   always_comb begin
      pick_d = d_req;
   end
`endif

   // Grant, completion and timeout decisions for the single outstanding transaction.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      bus_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               cnt_d = 8'd0;
               if (pick_d) begin
                  state_d = BUSY_D;
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
               end else begin
                  state_d = BUSY_IF;
                  addr_d  = if_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ack) begin
               state_d = IDLE;
               if (state_q == BUSY_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  d_ack_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
               if (state_q == BUSY_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = '0;
               end else begin
                  d_ack_d = 1'b1;
                  // A store never carries read data, so d_rdata is left alone.
                  if (!we_q) begin
                     d_rdata_d = '0;
                  end
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         cnt_q      <= 8'd0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Memory strobes follow the BUSY states; address and data come from the latched request.
   always_comb begin
      mem_en    = (state_q != IDLE);
      mem_we    = (state_q != IDLE) & we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if_rdata  = if_rdata_q;
      d_rdata   = d_rdata_q;
      if_ack    = if_ack_q;
      d_ack     = d_ack_q;
      bus_err   = bus_err_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level
// reference model compared against the DUT every cycle.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          bus_err;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // Reference model state: the one outstanding transaction plus expected port outputs.
   logic          mBusy = 1'b0;
   logic          mOwnerD = 1'b0;
   logic [AW-1:0] mAddr = '0;
   logic          mWe = 1'b0;
   logic [DW-1:0] mWdata = '0;
   int            mAge = 0;
   logic          mLastD = 1'b0;
   logic          eIfAck = 1'b0;
   logic          eDAck = 1'b0;
   logic          eErr = 1'b0;
   logic [DW-1:0] eIfRdata = '0;
   logic [DW-1:0] eDRdata = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr, input logic dReq,
                                input logic dWe, input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
      if_req  = ifReq;
      if_addr = ifAddr;
      d_req   = dReq;
      d_we    = dWe;
      d_addr  = dAddr;
      d_wdata = dWdata;
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   // Advance the model by one clock edge using the inputs sampled at that edge.
   task automatic modelStep();
      logic winD;
      eIfAck = 1'b0;
      eDAck  = 1'b0;
      eErr   = 1'b0;
      if (!rst_n) begin
         mBusy    = 1'b0;
         mAge     = 0;
         mLastD   = 1'b0;
         eIfRdata = '0;
         eDRdata  = '0;
      end else if (mBusy) begin
         mAge++;
         if (mem_ack || mAge == TO) begin
            mBusy = 1'b0;
            eErr  = !mem_ack;
            if (mOwnerD) begin
               eDAck = 1'b1;
               if (!mWe) eDRdata = mem_ack ? mem_rdata : '0;
            end else begin
               eIfAck   = 1'b1;
               eIfRdata = mem_ack ? mem_rdata : '0;
            end
         end
      end else if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
         winD = (if_req && d_req) ? !mLastD : d_req;
`else
         winD = d_req;
`endif
         mBusy   = 1'b1;
         mAge    = 0;
         mOwnerD = winD;
         mLastD  = winD;
         mAddr   = winD ? d_addr : if_addr;
         mWe     = winD ? d_we : 1'b0;
         mWdata  = d_wdata;
      end
   endtask

   // Model advances on each rising edge; DUT outputs are compared 1 ns later.
   initial begin
      forever begin
         @(posedge clk);
         modelStep();
         #1;
         checkOutput("mem_en", mem_en, mBusy);
         if (mBusy) begin
            checkOutput("mem_addr", mem_addr, mAddr);
            checkOutput("mem_we", mem_we, mWe);
            if (mWe) checkOutput("mem_wdata", mem_wdata, mWdata);
         end
         checkOutput("if_ack", if_ack, eIfAck);
         checkOutput("d_ack", d_ack, eDAck);
         checkOutput("bus_err", bus_err, eErr);
         checkOutput("if_rdata", if_rdata, eIfRdata);
         checkOutput("d_rdata", d_rdata, eDRdata);
      end
   end

   // Memory side: wait for a grant, ack in the delay-th BUSY cycle, return the granted address.
   task automatic serveOne(input int delay, input logic [DW-1:0] rdata, output logic [AW-1:0] grantedAddr);
      int guard = 0;
      while (mem_en !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         checkOutput("grant_wait", 64'd0, 64'd1);
         grantedAddr = '0;
      end else begin
         grantedAddr = mem_addr;
         repeat (delay - 1) step();
         mem_ack   = 1'b1;
         mem_rdata = rdata;
         step();
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] g;
      logic [AW-1:0] grants [4];
      logic [AW-1:0] expGrants [4];
      logic [DW-1:0] expDAfterTie;
`ifdef MEM_ARB_RR_EN
      expGrants    = '{32'h300, 32'h40, 32'h300, 32'h40};
      expDAfterTie = 32'h1111_0002;
`else
      expGrants    = '{32'h300, 32'h300, 32'h300, 32'h300};
      expDAfterTie = 32'h1111_0003;
`endif

      // Reset state
      step();
      step();
      checkOutput("rst_mem_en", mem_en, 1'b0);
      checkOutput("rst_if_ack", if_ack, 1'b0);
      checkOutput("rst_d_ack", d_ack, 1'b0);
      checkOutput("rst_bus_err", bus_err, 1'b0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      rst_n = 1'b1;
      step();

      // mem_ack while idle is ignored
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_ack = 1'b0;
      checkOutput("idle_ack_if", if_ack, 1'b0);
      checkOutput("idle_ack_d", d_ack, 1'b0);
      checkOutput("idle_ack_rdata", if_rdata, 32'h0);

      // Fetch from 0x10, ack one cycle after mem_en rises
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("f_mem_en", mem_en, 1'b1);
      checkOutput("f_mem_addr", mem_addr, 32'h10);
      checkOutput("f_mem_we", mem_we, 1'b0);
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h0050_0093;
      step();
      mem_ack = 1'b0;
      checkOutput("f_if_ack", if_ack, 1'b1);
      checkOutput("f_if_rdata", if_rdata, 32'h0050_0093);
      checkOutput("f_bus_err", bus_err, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("f_if_ack_end", if_ack, 1'b0);
      checkOutput("f_mem_en_end", mem_en, 1'b0);

      // Both ports requesting for four back-to-back transactions
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h0);
      for (int i = 0; i < 4; i++) begin
         serveOne(1, 32'h1111_0000 + 32'(i), g);
         grants[i] = g;
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("tie_grant%0d", i), grants[i], expGrants[i]);
      end
      step();

      // Store to 0x200, ack in the third BUSY cycle
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
      step();
      checkOutput("st_mem_we", mem_we, 1'b1);
      checkOutput("st_mem_addr", mem_addr, 32'h200);
      checkOutput("st_wdata1", mem_wdata, 32'hDEAD_BEEF);
      step();
      checkOutput("st_wdata2", mem_wdata, 32'hDEAD_BEEF);
      step();
      checkOutput("st_wdata3", mem_wdata, 32'hDEAD_BEEF);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      checkOutput("st_d_ack", d_ack, 1'b1);
      checkOutput("st_bus_err", bus_err, 1'b0);
      checkOutput("st_d_rdata_kept", d_rdata, expDAfterTie);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("st_single_ack", d_ack, 1'b0);

      // Load that never gets mem_ack: aborted after TO BUSY cycles
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      step();
      repeat (TO - 1) step();
      checkOutput("to_still_busy", mem_en, 1'b1);
      step();
      checkOutput("to_d_ack", d_ack, 1'b1);
      checkOutput("to_bus_err", bus_err, 1'b1);
      checkOutput("to_d_rdata", d_rdata, 32'h0);
      checkOutput("to_mem_en", mem_en, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Load acked exactly in the last allowed BUSY cycle completes normally
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);
      step();
      repeat (TO - 1) step();
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_CAFE;
      step();
      mem_ack = 1'b0;
      checkOutput("edge_d_ack", d_ack, 1'b1);
      checkOutput("edge_bus_err", bus_err, 1'b0);
      checkOutput("edge_d_rdata", d_rdata, 32'h0BAD_CAFE);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Reset asserted two cycles into a data transaction
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
      step();
      step();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_mem_en", mem_en, 1'b0);
      checkOutput("rst_mid_d_ack", d_ack, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      checkOutput("rst_hold_d_ack", d_ack, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
      serveOne(1, 32'h1234_5678, g);
      checkOutput("post_rst_addr", g, 32'h14);
      checkOutput("post_rst_if_ack", if_ack, 1'b1);
      checkOutput("post_rst_if_rdata", if_rdata, 32'h1234_5678);
      checkOutput("post_rst_bus_err", bus_err, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
